// File: rtl/blink_round_ctrl.sv
// Round sequencer for the Blink reaction game: random delay, lit target LED,
// shrinking response window, saturating hit score and a sticky loss flag.
module blink_round_ctrl #(
    parameter int TICK_DIV    = 100000,
    parameter int MIN_DELAY   = 500,
    parameter int DELAY_SCALE = 8,
    parameter int WINDOW_INIT = 1000,
    parameter int WINDOW_STEP = 50,
    parameter int WINDOW_MIN  = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] btn,
    output logic [3:0] led,
    output logic [3:0] score,
    output logic       lose,
    output logic       round_active,
    output logic [2:0] state_dbg_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_LIT  = 3'd2,
        S_HIT  = 3'd3,
        S_LOSE = 3'd4
    } state_e;

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [15:0] WIN_SHRINK_MIN = 16'(WINDOW_MIN + WINDOW_STEP);

    if (TICK_DIV < 1 || MIN_DELAY + 63 * DELAY_SCALE > 65535 || WINDOW_INIT > 65535 ||
        WINDOW_MIN + WINDOW_STEP > 65535 || WINDOW_MIN > WINDOW_INIT) begin : g_param_check
        $error("blink_round_ctrl: timer parameters do not fit in 16 bits");
    end

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [3:0]         btn_q;
    logic [3:0]         target_q, target_d;
    logic [15:0]        timer_q, timer_d;
    logic [15:0]        window_q, window_d;
    logic [3:0]         score_q, score_d;
    logic [3:0]         led_q, led_d;
    logic               lose_q, lose_d;
    logic               active_q, active_d;

    logic               tick;
    logic               expire;
    logic [3:0]         press;
    logic [3:0]         next_target;
    logic [15:0]        delay_val;
    logic [15:0]        window_dec;

    assign tick        = (presc_q == PRESC_MAX);
    assign presc_d     = tick ? '0 : presc_q + 1'b1;
    assign lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign press       = btn & ~btn_q;
    assign expire      = tick && (timer_q == 16'd0);
    assign next_target = 4'b0001 << lfsr_q[1:0];
    assign delay_val   = 16'(MIN_DELAY) + 16'(lfsr_q[7:2]) * 16'(DELAY_SCALE);
    assign window_dec  = (window_q >= WIN_SHRINK_MIN) ? window_q - 16'(WINDOW_STEP)
                                                      : 16'(WINDOW_MIN);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        target_d = target_q;
        window_d = window_q;
        score_d  = score_q;
        if ((state_q == S_WAIT || state_q == S_LIT) && tick && timer_q != 16'd0) begin
            timer_d = timer_q - 1'b1;
        end
        // enable low outranks presses and expiry; the checks below are in priority order
        case (state_q)
            S_IDLE: begin
                if (enable && !lose_q) begin
                    state_d  = S_WAIT;
                    timer_d  = delay_val;
                    target_d = next_target;
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (press != 4'b0) begin
                    state_d = S_LOSE;
                end else if (expire) begin
                    state_d = S_LIT;
                    timer_d = window_q;
                end
            end
            S_LIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (press != 4'b0) begin
                    state_d = (press == target_q) ? S_HIT : S_LOSE;
                end else if (expire) begin
                    state_d = S_LOSE;
                end
            end
            S_HIT: begin
                score_d  = (score_q == 4'hF) ? score_q : score_q + 1'b1;
                window_d = window_dec;
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_WAIT;
                    timer_d  = delay_val;
                    target_d = next_target;
                end
            end
            S_LOSE: begin
                state_d = S_LOSE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // outputs are registered from the next state so they line up with state_q
    assign led_d    = (state_d == S_LIT) ? target_d : 4'b0;
    assign lose_d   = lose_q | (state_d == S_LOSE);
    assign active_d = (state_d == S_WAIT) || (state_d == S_LIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            lfsr_q   <= 8'hA5;
            btn_q    <= 4'b0;
            target_q <= 4'b0;
            timer_q  <= 16'd0;
            window_q <= 16'(WINDOW_INIT);
            score_q  <= 4'd0;
            led_q    <= 4'b0;
            lose_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            lfsr_q   <= lfsr_d;
            btn_q    <= btn;
            target_q <= target_d;
            timer_q  <= timer_d;
            window_q <= window_d;
            score_q  <= score_d;
            led_q    <= led_d;
            lose_q   <= lose_d;
            active_q <= active_d;
        end
    end

    assign led          = led_q;
    assign score        = score_q;
    assign lose         = lose_q;
    assign round_active = active_q;
    assign state_dbg_o  = state_q;

endmodule
